fillrect: RTL and testbench

FILLRECT -- requirements
Module: fillrect

---
 rtl/fillrect.sv | 228 ++++++++++++++++++++++
 tb/tb_fillrect.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fillrect.sv
// ---------------------------------------------------------------------------
// fillrect -- rectangle fill engine for a pixel-plot VGA sink.
//
// Latches a rectangle (x0..x1, y0..y1 inclusive), a base colour and a fill
// pattern on start. It then emits one pixel per accepted handshake, in
// raster order.
//
// Handshake: a pixel is transferred on a rising edge where vga_plot and
// vga_ready are both high. While vga_plot is high and vga_ready is low,
// vga_x, vga_y and vga_colour hold stable. vga_plot never drops without
// an accepted transfer, except on reset.
//
// Optional feature (compile-time macro FILLRECT_CLIP_EN):
//   defined   - the SETUP cycle clamps x1/y1 to the screen's last column and
//               last row. A rectangle starting off-screen becomes empty.
//   undefined - no clamping. Any coordinate up to 2^XW-1 / 2^YW-1 is
//               plotted as given.
//
// Parameters:
//   SCREEN_W, SCREEN_H : screen size in pixels (the clip bounds)
//   XW, YW             : coordinate widths (2^XW >= SCREEN_W, 2^YW >= SCREEN_H)
//   CW                 : colour width
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : fill request, level-sampled in IDLE or DONE
//   x0, x1, y0, y1     : inclusive rectangle corners
//   colour, mode       : base colour; pattern 0 solid, 1 column stripe,
//                        2 row stripe, 3 diagonal
//   vga_ready          : sink ready
//   vga_x, vga_y       : current pixel coordinates
//   vga_colour         : current pixel colour
//   vga_plot           : pixel valid
//   busy               : high in SETUP and DRAW
//   done               : high in DONE
//   fsm_state          : state observation (0 IDLE, 1 SETUP, 2 DRAW, 3 DONE)
// ---------------------------------------------------------------------------
module fillrect #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour,
    input  logic [1:0]    mode,
    input  logic          vga_ready,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    output logic          busy,
    output logic          done,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_ZERO = '0;

    // Refuse to build with coordinate widths that cannot address the screen.
    generate
        if (((2 ** XW) < SCREEN_W) || ((2 ** YW) < SCREEN_H)) begin : g_bad_params
            $error("fillrect: XW/YW too narrow for SCREEN_W/SCREEN_H");
        end
    endgenerate

    state_t        state;

    // Latched request
    logic [XW-1:0] lx0;
    logic [XW-1:0] lx1;
    logic [YW-1:0] ly0;
    logic [YW-1:0] ly1;
    logic [CW-1:0] lcolour;
    logic [1:0]    lmode;

    // Walk position and its offset from the top-left corner. The offsets
    // only feed the colour pattern, so they are kept modulo 2^CW.
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;

    // Clipped far corner and the empty-rectangle test, evaluated in SETUP.
    logic [XW-1:0] clip_x1;
    logic [YW-1:0] clip_y1;
    logic          empty;

`ifdef FILLRECT_CLIP_EN
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

    always_comb begin
        clip_x1 = (lx1 > X_LAST) ? X_LAST : lx1;
        clip_y1 = (ly1 > Y_LAST) ? Y_LAST : ly1;
        // An off-screen start corner always exceeds the clamped far corner.
        // It is tested explicitly so the intent is visible.
        empty   = (lx0 > X_LAST) || (ly0 > Y_LAST) ||
                  (lx0 > clip_x1) || (ly0 > clip_y1);
    end
`else
    always_comb begin
        clip_x1 = lx1;
        clip_y1 = ly1;
        empty   = (lx0 > clip_x1) || (ly0 > clip_y1);
    end
`endif

    // Pattern colour for a pixel at offset (ddx, ddy) from the corner.
    function automatic logic [CW-1:0] pix_colour(
        input logic [1:0]    m,
        input logic [CW-1:0] c,
        input logic [CW-1:0] ddx,
        input logic [CW-1:0] ddy
    );
        logic [CW-1:0] r;
        case (m)
            2'd0:    r = c;
            2'd1:    r = c + ddx;
            2'd2:    r = c + ddy;
            default: r = c + ddx + ddy;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lx0        <= '0;
            lx1        <= '0;
            ly0        <= '0;
            ly1        <= '0;
            lcolour    <= '0;
            lmode      <= '0;
            x          <= '0;
            y          <= '0;
            dx         <= '0;
            dy         <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lx0     <= x0;
                        lx1     <= x1;
                        ly0     <= y0;
                        ly1     <= y1;
                        lcolour <= colour;
                        lmode   <= mode;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    // Keep the clipped corner so DRAW terminates on it.
                    lx1 <= clip_x1;
                    ly1 <= clip_y1;
                    if (empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x          <= lx0;
                        y          <= ly0;
                        dx         <= C_ZERO;
                        dy         <= C_ZERO;
                        vga_colour <= lcolour;   // every pattern equals base at offset 0
                        vga_plot   <= 1'b1;
                        state      <= DRAW;
                    end
                end

                DRAW: begin
                    if (vga_ready) begin
                        if (x == lx1) begin
                            if (y == ly1) begin
                                // Last pixel accepted. The counters stop on the
                                // far corner, so they never wrap.
                                vga_plot <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= DONE;
                            end else begin
                                x          <= lx0;
                                y          <= y + Y_ONE;
                                dx         <= C_ZERO;
                                dy         <= dy + C_ONE;
                                vga_colour <= pix_colour(lmode, lcolour, C_ZERO, dy + C_ONE);
                            end
                        end else begin
                            x          <= x + X_ONE;
                            dx         <= dx + C_ONE;
                            vga_colour <= pix_colour(lmode, lcolour, dx + C_ONE, dy);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign vga_x     = x;
    assign vga_y     = y;
    assign fsm_state = state;

endmodule

// File: tb/tb_fillrect.sv
module tb_fillrect;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int PW = XW + YW + CW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [CW-1:0] colour;
    logic [1:0]    mode;
    logic          vga_ready;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;
    logic          busy;
    logic          done;
    logic [1:0]    fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fillrect dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .colour     (colour),
        .mode       (mode),
        .vga_ready  (vga_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passed = 0;
    logic [PW-1:0] exp_q[$];
    int            accepted = 0;
    logic [CW-1:0] seen_13_5 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_pix(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got (%0d,%0d) colour %0d, expected (%0d,%0d) colour %0d",
                      name, act[PW-1 -: XW], act[CW+YW-1 -: YW], act[CW-1:0],
                      exp[PW-1 -: XW], exp[CW+YW-1 -: YW], exp[CW-1:0]);
    endtask

    task automatic push_pix(input int px, input int py, input int pc);
        exp_q.push_back({XW'(px), YW'(py), CW'(pc)});
    endtask

    function automatic int model_colour(input int m, input int c, input int ddx, input int ddy);
        int s;
        s = c;
        if (m == 1 || m == 3) s = s + ddx;
        if (m == 2 || m == 3) s = s + ddy;
        return s % (1 << CW);
    endfunction

    task automatic push_rect(input int xa, input int xb, input int ya, input int yb,
                             input int c, input int m);
        for (int py = ya; py <= yb; py++)
            for (int px = xa; px <= xb; px++)
                push_pix(px, py, model_colour(m, c, px - xa, py - ya));
    endtask

    // Monitor: pops an expectation on every accepted pixel and checks that
    // a stalled pixel is still presented unchanged on the next cycle.
    logic          hold_pend = 1'b0;
    logic [PW-1:0] held = '0;
    initial begin
        logic [PW-1:0] cur;
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            cur = {vga_x, vga_y, vga_colour};
            if (hold_pend && vga_plot) check_pix("hold_stable", cur, held);
            if (vga_plot && vga_ready) begin
                accepted++;
                if (vga_x == 8'd13 && vga_y == 7'd5) seen_13_5 = vga_colour;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) colour %0d, expected no pixel",
                             vga_x, vga_y, vga_colour);
                end else begin
                    e = exp_q.pop_front();
                    check_pix("pixel", cur, e);
                end
            end
            hold_pend = vga_plot && !vga_ready;
            held      = cur;
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 into cycle N+1.
    task automatic start_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                              input int ac, input int am, output int n);
        x0     = XW'(ax0);
        x1     = XW'(ax1);
        y0     = YW'(ay0);
        y1     = YW'(ay1);
        colour = CW'(ac);
        mode   = 2'(am);
        start  = 1'b1;
        n      = cyc;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n, input int lat, output int busy_cycles);
        int k;
        k = 0;
        busy_cycles = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cycles++;
            k++;
            if (k > 25000) break;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, k);
        end else begin
            check({name, "_latency"}, cyc - n, lat);
        end
        @(posedge clk); #1;
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, bc, acc0;
        int pat[5];
        pat = '{1, 0, 0, 1, 1};

        // Reset with start held high: reset wins.
        rst = 1'b1; start = 1'b1; vga_ready = 1'b1;
        x0 = 8'd5; x1 = 8'd9; y0 = 7'd3; y1 = 7'd4; colour = 3'd2; mode = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_plot", vga_plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        check("rst_state", fsm_state, 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst_state", fsm_state, 0);
        check("idle_after_rst_busy", busy, 0);

        // Row stripe, 3x3: rows colour 1, 2, 3.
        push_rect(3, 5, 10, 12, 1, 2);
        start_fill(3, 5, 10, 12, 1, 2, n);
        wait_done("row_stripe", n, 2 + 9, bc);
        check("row_stripe_busy", bc, 9 + 1);

        // Full screen, column stripe.
        acc0 = accepted;
        push_rect(0, 159, 0, 119, 0, 1);
        start_fill(0, 159, 0, 119, 0, 1, n);
        wait_done("full_screen", n, 19202, bc);
        check("full_screen_count", accepted - acc0, 19200);
        check("pixel_13_5_colour", seen_13_5, 5);

        // Backpressure: ready 1,0,0,1,1 from the first pixel cycle.
        acc0 = accepted;
        push_pix(2, 1, 6);
        push_pix(3, 1, 6);
        push_pix(4, 1, 6);
        start_fill(2, 4, 1, 1, 6, 0, n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vga_ready = pat[i][0];
        end
        vga_ready = 1'b1;
        wait_done("backpressure", n, 7, bc);
        check("backpressure_count", accepted - acc0, 3);

        // Empty rectangle.
        acc0 = accepted;
        start_fill(10, 9, 0, 0, 1, 0, n);
        wait_done("empty", n, 2, bc);
        check("empty_busy_cycles", bc, 1);
        check("empty_count", accepted - acc0, 0);

        // Rectangle past the screen edge.
        acc0 = accepted;
`ifdef FILLRECT_CLIP_EN
        push_rect(150, 159, 115, 119, 2, 0);
        start_fill(150, 200, 115, 127, 2, 0, n);
        wait_done("clip", n, 2 + 50, bc);
        check("clip_count", accepted - acc0, 50);
`else
        push_rect(150, 200, 115, 127, 2, 0);
        start_fill(150, 200, 115, 127, 2, 0, n);
        wait_done("noclip", n, 2 + 663, bc);
        check("noclip_count", accepted - acc0, 663);
`endif

        // Top of the coordinate range.
        acc0 = accepted;
`ifdef FILLRECT_CLIP_EN
        start_fill(254, 255, 126, 127, 4, 0, n);
        wait_done("corner_clip", n, 2, bc);
        check("corner_clip_count", accepted - acc0, 0);
`else
        push_pix(254, 126, 4);
        push_pix(255, 126, 4);
        push_pix(254, 127, 4);
        push_pix(255, 127, 4);
        start_fill(254, 255, 126, 127, 4, 0, n);
        wait_done("corner", n, 6, bc);
        check("corner_count", accepted - acc0, 4);
`endif

        // Reset during the 7th accepted pixel.
        acc0 = accepted;
        for (int i = 0; i < 7; i++) push_pix(i, 0, 3);
        start_fill(0, 9, 0, 0, 3, 0, n);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_plot", vga_plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_state", fsm_state, 0);
        check("midrst_count", accepted - acc0, 7);
        rst = 1'b0;
        push_pix(4, 2, 5);
        push_pix(5, 2, 5);
        start_fill(4, 5, 2, 2, 5, 0, n);
        wait_done("after_rst", n, 4, bc);

        // Restart from DONE with start held; inputs changed mid-fill are ignored.
        push_pix(0, 0, 7);
        push_pix(1, 0, 0);
        push_pix(0, 1, 0);
        push_pix(1, 1, 1);
        x0 = 8'd0; x1 = 8'd1; y0 = 7'd0; y1 = 7'd1; colour = 3'd7; mode = 2'd3;
        start = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        x0 = 8'd50; x1 = 8'd60; y0 = 7'd20; y1 = 7'd30; colour = 3'd1; mode = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart", n, 6, bc);
        repeat (2) @(posedge clk);
        #1;
        check("done_holds", done, 1);
        check("done_state", fsm_state, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
